perm_access_arbiter: RTL

PERM_ACCESS_ARBITER -- requirements
Module: perm_access_arbiter

---
 rtl/perm_access_arbiter.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/perm_access_arbiter.sv
// Two-port arbiter in front of a bank of protected registers. Each access is
// granted round-robin, checked against a per-register permission table, then
// turned into a single one-hot strobe on the shared bank bus.
// Optional feature: define PERM_LOCK_EN to add cfg_lock, a sticky lock that
// freezes the permission table until reset.
module perm_access_arbiter #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 3
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     req_a,
    input  logic                     req_b,
    input  logic                     we_a,
    input  logic                     we_b,
    input  logic [ADDR_W-1:0]        addr_a,
    input  logic [ADDR_W-1:0]        addr_b,
    input  logic [WIDTH-1:0]         wdata_a,
    input  logic [WIDTH-1:0]         wdata_b,
    output logic                     ack_a,
    output logic                     ack_b,
    output logic                     fault,
    output logic [WIDTH-1:0]         rdata,
    input  logic                     cfg_we,
    input  logic [ADDR_W-1:0]        cfg_addr,
    input  logic [3:0]               cfg_perm,
`ifdef PERM_LOCK_EN
    input  logic                     cfg_lock,
`endif
    output logic [(2**ADDR_W)-1:0]   bank_we,
    output logic [(2**ADDR_W)-1:0]   bank_re,
    output logic [WIDTH-1:0]         bank_wdata,
    input  logic [WIDTH-1:0]         bank_rdata
);

    localparam int unsigned DEPTH = 2**ADDR_W;

    typedef enum logic [2:0] {IDLE, CHECK, ACCESS, CAPTURE, RESP} state_t;

    state_t              state;
    logic                gnt_b;
    logic                last_b;
    logic                lat_we;
    logic                denied;
    logic [ADDR_W-1:0]   lat_addr;
    logic [3:0]          perm [DEPTH];

    logic                elig_a;
    logic                elig_b;
    logic                pick_b;
    logic                perm_bit;
    logic                cfg_ok;

    // A requester whose ack is still visible is not re-granted on the same edge
    assign elig_a   = req_a & ~ack_a;
    assign elig_b   = req_b & ~ack_b;
    assign pick_b   = elig_b & (~elig_a | ~last_b);
    // Permission bit order is {wr_b, rd_b, wr_a, rd_a}
    assign perm_bit = perm[lat_addr][{gnt_b, lat_we}];

`ifdef PERM_LOCK_EN
    logic lock;

    // Sticky lock: once set, the permission table is frozen until reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lock <= 1'b0;
        end else if (cfg_lock) begin
            lock <= 1'b1;
        end
    end

    assign cfg_ok = cfg_we & ~lock;
`else
    assign cfg_ok = cfg_we;
`endif

    // Permission table: written in any state; a same-edge CHECK sees the old entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                perm[i] <= 4'b0000;
            end
        end else if (cfg_ok) begin
            perm[cfg_addr] <= cfg_perm;
        end
    end

    // Access sequencer with registered strobes, ack, fault and read data
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            gnt_b      <= 1'b0;
            last_b     <= 1'b1;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            denied     <= 1'b0;
            ack_a      <= 1'b0;
            ack_b      <= 1'b0;
            fault      <= 1'b0;
            rdata      <= '0;
            bank_we    <= '0;
            bank_re    <= '0;
            bank_wdata <= '0;
        end else begin
            ack_a   <= 1'b0;
            ack_b   <= 1'b0;
            bank_we <= '0;
            bank_re <= '0;
            case (state)
                IDLE: begin
                    fault <= 1'b0;
                    if (elig_a || elig_b) begin
                        gnt_b      <= pick_b;
                        last_b     <= pick_b;
                        lat_we     <= pick_b ? we_b : we_a;
                        lat_addr   <= pick_b ? addr_b : addr_a;
                        bank_wdata <= pick_b ? wdata_b : wdata_a;
                        denied     <= 1'b0;
                        state      <= CHECK;
                    end
                end
                CHECK: begin
                    if (perm_bit) begin
                        if (lat_we) begin
                            bank_we <= DEPTH'(1) << lat_addr;
                        end else begin
                            bank_re <= DEPTH'(1) << lat_addr;
                        end
                        state <= ACCESS;
                    end else begin
                        denied <= 1'b1;
                        state  <= RESP;
                    end
                end
                ACCESS: begin
                    state <= lat_we ? RESP : CAPTURE;
                end
                CAPTURE: begin
                    rdata <= bank_rdata;
                    state <= RESP;
                end
                RESP: begin
                    ack_a <= ~gnt_b;
                    ack_b <= gnt_b;
                    fault <= denied;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
